// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial multi-precision adder.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshakes of nibble_serial_adder.
// Optional macro SIGNED_OVF_EN adds the ovf_out signal.
interface nibble_serial_adder_if
  import nsa_pkg::*;
#(
  parameter int NIB = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [NIB_W*NIB-1:0]   a_in;
  logic [NIB_W*NIB-1:0]   b_in;
  logic                   cin_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [NIB_W*NIB:0]     sum_out;
`ifdef SIGNED_OVF_EN
  logic                   ovf_out;
`endif

  modport master (
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum_out
`ifdef SIGNED_OVF_EN
    , input ovf_out
`endif
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum_out
`ifdef SIGNED_OVF_EN
    , output ovf_out
`endif
  );

endinterface

// File: rtl/nibble_serial_adder_rc1.sv
// rc1: 4-bit ripple-carry adder, S[4] is the carry-out.
module rc1 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [4:0] S
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign S[4] = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: streams operands through rc1 one nibble per clock, LSB first.
// Optional macro SIGNED_OVF_EN adds ovf_out (signed overflow at width 4*NIB).
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int W     = NIB_W * NIB;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  nsa_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W:0]       sum_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W:0]   s_nib;

  assign a_nib = a_q[NIB_W*idx +: NIB_W];
  assign b_nib = b_q[NIB_W*idx +: NIB_W];

  rc1 u_rc1 (
    .A   (a_nib),
    .B   (b_nib),
    .Cin (carry),
    .S   (s_nib)
  );

`ifdef SIGNED_OVF_EN
  // Carry into the operand MSB: only meaningful while the top nibble is on rc1.
  logic [NIB_W-1:0] low_sum;
  logic             ovf_q;

  assign low_sum = {1'b0, a_nib[NIB_W-2:0]} + {1'b0, b_nib[NIB_W-2:0]}
                 + {{(NIB_W-1){1'b0}}, carry};
`endif

  // NOTE: all state, including the operand and sum datapath, resets
  // asynchronously so an abort mid-transaction leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; every read sees the
      // pre-edge value, so the carry chains cleanly from nibble to nibble.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a_in;
            b_q        <= bus.b_in;
            carry      <= bus.cin_in;
            sum_q      <= '0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end

        RUN: begin
          sum_q[NIB_W*idx +: NIB_W] <= s_nib[NIB_W-1:0];
          carry                     <= s_nib[NIB_W];
          if (idx == LAST_IDX) begin
            sum_q[W]    <= s_nib[NIB_W];
            idx         <= '0;
            out_valid_q <= 1'b1;
`ifdef SIGNED_OVF_EN
            ovf_q       <= low_sum[NIB_W-1] ^ s_nib[NIB_W];
`endif
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            idx         <= '0;
`ifdef SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
`ifdef SIGNED_OVF_EN
  assign bus.ovf_out   = ovf_q;
`endif

endmodule
